vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the raster scan that drives the character pixel generators: pixel-rate tick, current X/Y coordinates, and horizontal/vertical sync. Sits directly upstream of the letter pixel stage, which consumes x and y. The top level gates letter pixels with video_on and sends hsync/vsync to the VGA connector. Defaults give 640x480@60 Hz from a 50 MHz clock.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes the scan
pix_tick  out  1  one-clk pulse per pixel period
x  out  10  horizontal counter, 0..H_TOTAL-1
y  out  10  vertical counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
video_on  out  1  high when x<H_VISIBLE and y<V_VISIBLE
line_start  out  1  one-clk pulse when x becomes 0
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = sum of the V terms (525).
- H_TOTAL and V_TOTAL must be <=1024. Counters are 10 bits unsigned.
- Reset (async assert, sync release) sets:
  - divider, h_cnt, v_cnt, x, y = 0
  - pix_tick, video_on, line_start, frame_start = 0
  - hsync, vsync = ~SYNC_POL
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. pix_tick is registered and high for exactly the cycle after div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly high while en=1.
  - The first pix_tick follows reset release by CLK_DIV cycles.
- Scan: on each clk edge with pix_tick=1:
  - If h_cnt==H_TOTAL-1: h_cnt wraps to 0. Then v_cnt wraps to 0 if v_cnt==V_TOTAL-1, else increments.
  - Otherwise h_cnt increments.
- Output alignment: all outputs are registered and decoded from next-state counter values. x, y, hsync, vsync and video_on change on the same edge, with zero relative skew.
- hsync asserted while H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vsync asserted while V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- video_on = (x<H_VISIBLE)&&(y<V_VISIBLE).
- x and y are not clamped outside the visible area; consumers must gate with video_on.
- line_start and frame_start:
  - Each is high for exactly one clk, on the edge where the counter wraps to 0.
  - frame_start implies line_start.
  - Neither pulses at reset release, even though the counters start at (0,0).
- en=0:
  - Divider and counters hold; pix_tick=0.
  - x and y hold.
  - video_on, line_start, frame_start = 0.
  - hsync and vsync are forced inactive.
- en 0->1: resumes from the held div_cnt and counters. Sync and video_on re-evaluate on the next edge.
- Reset mid-line or mid-frame: immediate async return to the reset state. The scan restarts from (0,0) with no partial pulses.

Test Plan:
- Reset release, en=1, defaults -> first pix_tick at clk 2. x reaches 799 then wraps to 0 and y=1 after 1600 clks; line_start pulses once at the wrap.
- Full frame -> 840000 clks between frame_start pulses; video_on count = 307200 pix_ticks per frame; frame_start coincides with line_start.
- Line scan -> hsync low exactly for x=656..751 (192 clks), high elsewhere. vsync low exactly on y=490..491 (1600 ticks). video_on=0 at x=640 and at y=480.
- en=0 for 100 clks at (x,y)=(300,200) -> x and y hold; pix_tick, video_on=0; syncs high. On re-enable, x=301 after the next tick.
- rst_n pulsed low mid-frame at (700,495) -> all outputs return to reset values immediately. Restart at (0,0) with no frame_start until the next wrap.
- CLK_DIV=1, SYNC_POL=1 -> pix_tick constant high; hsync high for 96 clks per 800-clk line.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate tick, X/Y scan counters and sync/blanking decode.
// Outputs are registered from next-state counter values so that x, y, syncs and video_on change together.
module vga_timing_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]      H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0]      HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0]      HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0]      V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0]      VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0]      VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             tick_q, hsync_q, vsync_q, video_q, line_q, frame_q;
  logic             h_wrap_s, v_wrap_s, hs_act_s, vs_act_s, vis_s;

  // Next-state divider and scan counters; everything freezes while en is low.
  always_comb begin
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    h_wrap_s = 1'b0;
    v_wrap_s = 1'b0;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (tick_q) begin
        if (h_q == H_LAST) begin
          h_d      = 10'd0;
          h_wrap_s = 1'b1;
          if (v_q == V_LAST) begin
            v_d      = 10'd0;
            v_wrap_s = 1'b1;
          end else begin
            v_d = v_q + 10'd1;
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end else begin
        h_d = h_q;
      end
    end else begin
      div_d = div_q;
    end
  end

  // Sync and blanking decode on the next-state position.
  always_comb begin
    hs_act_s = en && ({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END);
    vs_act_s = en && ({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END);
    vis_s    = en && ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      tick_q  <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      tick_q  <= en && (div_q == DIV_LAST);
      hsync_q <= hs_act_s ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_act_s ? SYNC_POL : ~SYNC_POL;
      video_q <= vis_s;
      line_q  <= h_wrap_s;
      frame_q <= v_wrap_s;
    end
  end

  assign pix_tick    = tick_q;
  assign x           = h_q;
  assign y           = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: two instances (default timing, and a small fast raster with
// CLK_DIV=1 / active-high sync) checked every clock against a linear-pixel-index reference model.
module tb_vga_timing_gen;

  typedef struct {
    int   div;
    int   hv, hf, hs, hb;
    int   vv, vf, vs, vb;
    logic pol;
  } cfg_t;

  typedef struct {
    int   phase;
    int   pos;
    logic tick;
    logic ls;
    logic fs;
    logic en_last;
  } m_t;

  localparam cfg_t C0 = '{div: 2, hv: 640, hf: 16, hs: 96, hb: 48,
                          vv: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
  localparam cfg_t C1 = '{div: 1, hv: 20, hf: 3, hs: 4, hb: 5,
                          vv: 10, vf: 2, vs: 2, vb: 3, pol: 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic       pt0, hs0, vs0, vo0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pt1, hs1, vs1, vo1, ls1, fs1;
  logic [9:0] x1, y1;

  int n_cmp = 0;
  int n_err = 0;
  m_t m0, m1;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .pix_tick(pt0), .x(x0), .y(y0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .pix_tick(pt1), .x(x1), .y(y1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .line_start(ls1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic m_t m_reset();
    m_t r;
    r.phase = 0; r.pos = 0; r.tick = 1'b0; r.ls = 1'b0; r.fs = 1'b0; r.en_last = 1'b0;
    return r;
  endfunction

  // One clock of the reference: the raster is a single pixel index walking 0..HT*VT-1.
  function automatic m_t m_step(m_t s, cfg_t c, logic en);
    m_t   n = s;
    int   ht = c.hv + c.hf + c.hs + c.hb;
    int   vt = c.vv + c.vf + c.vs + c.vb;
    n.en_last = en;
    n.ls = 1'b0;
    n.fs = 1'b0;
    n.tick = 1'b0;
    if (en) begin
      if (s.tick) begin
        n.pos = (s.pos + 1) % (ht * vt);
        n.ls  = (n.pos % ht) == 0;
        n.fs  = n.pos == 0;
      end
      n.tick  = (s.phase == c.div - 1);
      n.phase = (s.phase + 1) % c.div;
    end
    return n;
  endfunction

  task automatic cmp_dut(input string p, input m_t m, input cfg_t c,
                         input logic pt, input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs, input logic vo,
                         input logic ls, input logic fs);
    int   ht = c.hv + c.hf + c.hs + c.hb;
    int   ex = m.pos % ht;
    int   ey = m.pos / ht;
    logic hact = m.en_last && (ex >= c.hv + c.hf) && (ex < c.hv + c.hf + c.hs);
    logic vact = m.en_last && (ey >= c.vv + c.vf) && (ey < c.vv + c.vf + c.vs);
    chk({p, ".pix_tick"}, {31'd0, pt}, {31'd0, m.tick});
    chk({p, ".x"}, {22'd0, x}, ex);
    chk({p, ".y"}, {22'd0, y}, ey);
    chk({p, ".hsync"}, {31'd0, hs}, {31'd0, hact ? c.pol : ~c.pol});
    chk({p, ".vsync"}, {31'd0, vs}, {31'd0, vact ? c.pol : ~c.pol});
    chk({p, ".video_on"}, {31'd0, vo}, {31'd0, m.en_last && ex < c.hv && ey < c.vv});
    chk({p, ".line_start"}, {31'd0, ls}, {31'd0, m.ls});
    chk({p, ".frame_start"}, {31'd0, fs}, {31'd0, m.fs});
  endtask

  task automatic cmp_all();
    cmp_dut("d0", m0, C0, pt0, x0, y0, hs0, vs0, vo0, ls0, fs0);
    cmp_dut("d1", m1, C1, pt1, x1, y1, hs1, vs1, vo1, ls1, fs1);
  endtask

  initial begin
    int off0 = 0;
    int off1 = 0;
    int rst_hold = 0;
    int f1_seen = 0;
    m0 = m_reset();
    m1 = m_reset();
    repeat (3) @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      if (rst_n) begin
        m0 = m_step(m0, C0, en0);
        m1 = m_step(m1, C1, en1);
      end
      @(negedge clk);
      cmp_all();
      if (fs1) f1_seen++;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (cyc == 12000 || $urandom_range(0, 4999) == 0) begin
        rst_n = 1'b0;
        #1;
        m0 = m_reset();
        m1 = m_reset();
        cmp_all();
        rst_hold = $urandom_range(1, 3);
      end
      if (off0 > 0) off0--;
      else if ($urandom_range(0, 199) == 0) off0 = $urandom_range(1, 100);
      if (off1 > 0) off1--;
      else if ($urandom_range(0, 29) == 0) off1 = $urandom_range(1, 20);
      en0 = (off0 == 0);
      en1 = (off1 == 0);
    end
    chk("d1.frames_seen_nonzero", {31'd0, f1_seen > 5}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
